// File: rtl/p1_cache_controller.sv
// Processor-1 private L1 controller: direct-mapped MSI cache, directory requests and probe handling.
// Optional hit/miss statistics counters are enabled by defining CACHE_STATS_EN.
module p1_cache_controller #(
  parameter int NUM_LINES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       proc_valid,
  input  logic       operationP1,
  input  logic [7:0] addressP1,
  input  logic [7:0] dataP1,
  output logic       proc_stall,
  output logic       proc_done,
  output logic [7:0] proc_rdata,
  output logic       dir_req_valid,
  output logic [1:0] dir_req_type,
  output logic [7:0] dir_req_addr,
  output logic [7:0] dir_req_data,
  input  logic       dir_req_ready,
  input  logic       dir_resp_valid,
  input  logic [7:0] dir_resp_data,
  input  logic       dir_probe_valid,
  input  logic       dir_probe_type,
  input  logic [7:0] dir_probe_addr,
  output logic       probe_ack,
  output logic [7:0] probe_data
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int IDXW = $clog2(NUM_LINES);
  localparam int TAGW = 8 - IDXW;

  localparam logic [1:0] GetS = 2'd0;
  localparam logic [1:0] GetM = 2'd1;
  localparam logic [1:0] PutM = 2'd2;

  typedef enum logic [1:0] {IDLE, WB, REQ, WAIT} stateT;
  typedef enum logic [1:0] {MSI_I = 2'd0, MSI_S = 2'd1, MSI_M = 2'd2} msiT;

  stateT state, nextState;

  msiT            lineState [NUM_LINES];
  logic [TAGW-1:0] lineTag  [NUM_LINES];
  logic [7:0]      lineData [NUM_LINES];

  logic       reqOp;
  logic [7:0] reqAddr;
  logic [7:0] reqData;

  logic [IDXW-1:0] procIdx, probeIdx, reqIdx;
  logic [TAGW-1:0] procTag, probeTag, reqTag;

  assign procIdx  = addressP1[IDXW-1:0];
  assign procTag  = addressP1[7:IDXW];
  assign probeIdx = dir_probe_addr[IDXW-1:0];
  assign probeTag = dir_probe_addr[7:IDXW];
  assign reqIdx   = reqAddr[IDXW-1:0];
  assign reqTag   = reqAddr[7:IDXW];

  logic probeHit;
  msiT  probeNewState;
  msiT  procState;
  logic tagMatch;
  logic procHit;
  logic needWb;

  // The processor lookup sees the line as it will be after a same-cycle probe.
  always_comb begin
    probeHit      = dir_probe_valid && (lineTag[probeIdx] == probeTag) && (lineState[probeIdx] != MSI_I);
    probeNewState = MSI_I;
    if (dir_probe_type)
      probeNewState = (lineState[probeIdx] == MSI_M) ? MSI_S : lineState[probeIdx];
    procState = lineState[procIdx];
    if (probeHit && (probeIdx == procIdx))
      procState = probeNewState;
    tagMatch = (lineTag[procIdx] == procTag);
    procHit  = proc_valid && tagMatch && (operationP1 ? (procState == MSI_M) : (procState != MSI_I));
    needWb   = (procState == MSI_M) && !tagMatch;
  end

  always_comb begin
    nextState     = state;
    proc_stall    = 1'b0;
    dir_req_valid = 1'b0;
    dir_req_type  = GetS;
    dir_req_addr  = 8'h00;
    dir_req_data  = 8'h00;
    case (state)
      IDLE: begin
        if (proc_valid && !procHit) begin
          proc_stall = 1'b1;
          nextState  = needWb ? WB : REQ;
        end
      end
      WB: begin
        proc_stall = 1'b1;
        // A probe may have taken the victim away; then there is nothing to write back.
        if (lineState[reqIdx] == MSI_M) begin
          dir_req_valid = 1'b1;
          dir_req_type  = PutM;
          dir_req_addr  = {lineTag[reqIdx], reqIdx};
          dir_req_data  = lineData[reqIdx];
          if (dir_req_ready)
            nextState = REQ;
        end else begin
          nextState = REQ;
        end
      end
      REQ: begin
        proc_stall    = 1'b1;
        dir_req_valid = 1'b1;
        dir_req_type  = reqOp ? GetM : GetS;
        dir_req_addr  = reqAddr;
        if (dir_req_ready)
          nextState = WAIT;
      end
      WAIT: begin
        proc_stall = 1'b1;
        if (dir_resp_valid)
          nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= nextState;
  end

  // Probe update is written first so that writeback and fill assignments win on the same line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        lineState[i] <= MSI_I;
        lineTag[i]   <= '0;
        lineData[i]  <= 8'h00;
      end
      reqOp      <= 1'b0;
      reqAddr    <= 8'h00;
      reqData    <= 8'h00;
      proc_done  <= 1'b0;
      proc_rdata <= 8'h00;
      probe_ack  <= 1'b0;
      probe_data <= 8'h00;
    end else begin
      proc_done  <= 1'b0;
      probe_ack  <= dir_probe_valid;
      probe_data <= (probeHit && (lineState[probeIdx] == MSI_M)) ? lineData[probeIdx] : 8'h00;
      if (probeHit)
        lineState[probeIdx] <= probeNewState;
      case (state)
        IDLE: begin
          if (procHit) begin
            proc_done <= 1'b1;
            if (operationP1) begin
              lineData[procIdx] <= dataP1;
              proc_rdata        <= dataP1;
            end else begin
              proc_rdata <= lineData[procIdx];
            end
          end else if (proc_valid) begin
            reqOp   <= operationP1;
            reqAddr <= addressP1;
            reqData <= dataP1;
          end
        end
        WB: begin
          if ((lineState[reqIdx] == MSI_M) && dir_req_ready)
            lineState[reqIdx] <= MSI_I;
        end
        WAIT: begin
          if (dir_resp_valid) begin
            lineTag[reqIdx]   <= reqTag;
            lineState[reqIdx] <= reqOp ? MSI_M : MSI_S;
            lineData[reqIdx]  <= reqOp ? reqData : dir_resp_data;
            proc_rdata        <= reqOp ? reqData : dir_resp_data;
            proc_done         <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= 16'h0000;
      miss_count <= 16'h0000;
    end else begin
      if ((state == IDLE) && procHit && (hit_count != 16'hFFFF))
        hit_count <= hit_count + 16'd1;
      if ((state == WAIT) && dir_resp_valid && (miss_count != 16'hFFFF))
        miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/p1_cache_controller.md
# p1_cache_controller

Private L1 cache controller for processor 1 in the directory-based coherence system. Sits directly downstream of the processor model: it consumes each cycle's operation/address/data triple, services hits from a small direct-mapped MSI cache, and turns misses, upgrades and dirty evictions into request transactions toward the directory. It also answers directory probes (invalidate / downgrade) for lines it holds.

## Interface
Parameters:
- NUM_LINES, 4, cache lines, power of two ≥ 2; index = addressP1[log2(NUM_LINES)-1:0], tag = remaining upper address bits
- Each line holds one 8-bit data word, a tag and a 2-bit MSI state (I=0, S=1, M=2)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- proc_valid  in  1  processor request present this cycle
- operationP1  in  1  0 = read, 1 = write
- addressP1  in  8  request address
- dataP1  in  8  write data, ignored on reads
- proc_stall  out  1  request not accepted; processor holds the triple stable
- proc_done  out  1  one-cycle pulse, request completed
- proc_rdata  out  8  read data, valid while proc_done=1
- dir_req_valid  out  1  request to directory
- dir_req_type  out  2  0 = GetS, 1 = GetM, 2 = PutM
- dir_req_addr  out  8  request address
- dir_req_data  out  8  writeback data (PutM), else 0
- dir_req_ready  in  1  directory accepts request this cycle
- dir_resp_valid  in  1  fill/grant response, one cycle
- dir_resp_data  in  8  fill data
- dir_probe_valid  in  1  probe from directory, one cycle
- dir_probe_type  in  1  0 = invalidate, 1 = downgrade M→S
- dir_probe_addr  in  8  probed address
- probe_ack  out  1  one-cycle ack, cycle after probe
- probe_data  out  8  line data if line was M, else 0
- hit_count, miss_count  out  16 each  only with CACHE_STATS_EN

## Operation
- FSM states: IDLE, WB, REQ, WAIT.
- IDLE, proc_valid=1: tag match and state permits (read: S/M; write: M) → hit; write updates data, proc_done next cycle. Otherwise miss.
- Miss with victim in M and different tag → WB: issue PutM with victim address/data; victim → I on handshake; then REQ.
- REQ: dir_req_valid held with stable fields until dir_req_ready=1; type GetS for read, GetM for write (including S→M upgrade). Handshake → WAIT.
- WAIT: on dir_resp_valid install tag; read → S, data = dir_resp_data; write → M, data = dataP1. proc_done next cycle, then IDLE.
- Probes handled in any state: matching tag and state ≠ I → invalidate sets I, downgrade sets M→S (S unchanged); probe_data = line data if it was M. Non-matching/I → ack with probe_data=0. Probe hitting the line currently in WAIT updates the old contents; the fill overwrites afterward.
- Probe and processor request arriving together in IDLE: probe applied first; the processor lookup uses post-probe state.
- Reset: all lines I, tags 0, data 0, FSM IDLE, every output 0 (proc_stall 0).

## Timing
- Hit: request sampled at edge N, proc_done/proc_rdata at N+1; proc_stall 0. Back-to-back hits every cycle.
- Miss: proc_stall=1 combinationally from the sampling cycle until proc_done; dir_req_valid rises the cycle after sampling; proc_done one cycle after dir_resp_valid.
- Eviction adds ≥1 cycle (PutM handshake) before GetM/GetS.
- probe_ack exactly one cycle after dir_probe_valid, independent of FSM state.
- dir_resp_valid outside WAIT is ignored.
- rst_n asserted mid-transaction: immediate return to reset state, request abandoned, no ack.

## Configuration
- CACHE_STATS_EN defined: hit_count/miss_count ports exist, increment once per completed hit/miss (saturate at 16'hFFFF, reset 0). Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Cold read 0x04 → GetS 0x04, response 0x55 → proc_rdata 0x55, line S; re-read 0x04 hits next cycle, no dir_req.
- Write 0x04 data 0x80 while S → GetM upgrade; after response, line M holding 0x80; read 0x04 hits 0x80.
- Line at index 0 in M (0x04, 0x80); read 0x08 → PutM 0x04 data 0x80, then GetS 0x08.
- Probe invalidate 0x04 while M → probe_ack next cycle, probe_data 0x80; subsequent read 0x04 misses.
- dir_req_ready low 5 cycles → dir_req_valid/type/addr stable throughout, proc_stall held.
- rst_n pulsed in WAIT → all outputs 0, later read of prior address misses; with CACHE_STATS_EN counters read 0.
